// File: rtl/restador_pkg.sv
// restador_pkg: shared definitions for the bit-serial subtractor.
//   state_t        - control FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  - default operand/result width
//   clog2()        - bits needed to count WIDTH operand bits (0..WIDTH-1)
package restador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Ceiling log2; returns at least 1 so a counter always has one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/resta_1bit.sv
// resta_1bit: combinational 1-bit full subtractor, a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in from the less significant bit
//   d    out 1  difference bit
//   bout out 1  borrow out to the more significant bit
module resta_1bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when b exceeds a, or when a == b and a borrow is pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/restador_serial.sv
// restador_serial: bit-serial WIDTH-bit subtractor computing A - B, LSB first,
// with a registered borrow chain and a parallel result once all bits are in.
// Optional feature macro: RESTADOR_OVF_EN adds the signed-overflow port ovf.
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   start      in  1      pulse: begin or restart an operation
//   in_valid   in  1      a_bit/b_bit valid this cycle
//   a_bit      in  1      minuend bit, LSB first
//   b_bit      in  1      subtrahend bit, LSB first
//   busy       out 1      operation in progress
//   done       out 1      result valid and stable
//   diff       out WIDTH  A - B mod 2^WIDTH
//   borrow_out out 1      1 when A < B (unsigned)
//   ovf        out 1      signed overflow (RESTADOR_OVF_EN only)
module restador_serial
   import restador_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef RESTADOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
`ifdef RESTADOR_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic accept;
   logic last_bit;
   logic d_bit;
   logic bout_bit;

   // A bit is taken only in RUN and only when no restart is requested.
   assign accept   = (state_q == RUN) && in_valid && !start;
   assign last_bit = (cnt_q == LAST_CNT);

   resta_1bit u_resta (
      .a    (a_bit),
      .b    (b_bit),
      .bin  (borrow_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (start)                  state_d = RUN;
            else if (accept && last_bit) state_d = DONE;
         end
         DONE: begin
            if (start) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs (decoded from state register) ----------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // ---------------- Datapath next-state ----------------
   always_comb begin
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
`ifdef RESTADOR_OVF_EN
      ovf_d    = ovf_q;
`endif
      if (start) begin
         // Restart wipes every trace of a previous or partial operation.
         cnt_d    = '0;
         borrow_d = 1'b0;
         diff_d   = '0;
         bout_d   = 1'b0;
`ifdef RESTADOR_OVF_EN
         ovf_d    = 1'b0;
`endif
      end else if (accept) begin
         // Shift right so the first (LSB) bit lands in diff[0] after WIDTH bits.
         diff_d   = {d_bit, diff_q[WIDTH-1:1]};
         borrow_d = bout_bit;
         if (last_bit) begin
            cnt_d  = '0;
            bout_d = bout_bit;
`ifdef RESTADOR_OVF_EN
            // Operands of different sign and result sign differs from A.
            ovf_d  = (a_bit ^ b_bit) & (d_bit ^ a_bit);
`endif
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
      end
   end

`ifdef RESTADOR_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule

// File: tb/tb_restador_serial.sv
// tb_restador_serial: table-driven, scoreboard-checked bench for restador_serial.
// Build with +define+RESTADOR_OVF_EN to include the ovf port and its checks.
module tb_restador_serial;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         in_valid;
   logic         a_bit;
   logic         b_bit;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef RESTADOR_OVF_EN
   logic         ovf;
`endif

   restador_serial #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .a_bit      (a_bit),
      .b_bit      (b_bit),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef RESTADOR_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           gaps;
      bit           junk;
      logic [W-1:0] e_diff;
      bit           e_borrow;
      bit           e_ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] diff;
      bit           borrow;
      bit           ovf;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];

   int n_checks = 0;
   int n_pass   = 0;
   int ticks    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ticks++;
   endtask

   // busy and done must never be high together.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         n_checks++;
         if (!(busy && done)) n_pass++;
         else $display("FAIL busy_done_excl: busy=%b done=%b, expected not both", busy, done);
      end
   end

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.diff   = a - b;
      e.borrow = (a < b);
      e.ovf    = (a[W-1] ^ b[W-1]) & (e.diff[W-1] ^ a[W-1]);
      return e;
   endfunction

   // Start pulse; optionally with a junk bit that must be ignored.
   task automatic begin_op(input bit junk);
      start    = 1'b1;
      in_valid = junk;
      a_bit    = junk;
      b_bit    = 1'b0;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("done_after_start", done, 0);
   endtask

   task automatic feed_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            tick();
            chk("busy_in_gap", busy, 1);
         end
         in_valid = 1'b1;
         a_bit    = a[i];
         b_bit    = b[i];
         tick();
         in_valid = 1'b0;
      end
   endtask

   task automatic finish_op(input string name, input int t0, input int exp_lat);
      exp_t e;
      for (int k = 0; k < 4 && done !== 1'b1; k++) tick();
      chk({"done_", name}, done, 1);
      if (exp_lat > 0) chk({"latency_", name}, ticks - t0, exp_lat);
      if (sb.size() == 0) begin
         chk({"sb_empty_", name}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({"diff_", name}, diff, e.diff);
         chk({"borrow_", name}, borrow_out, e.borrow);
`ifdef RESTADOR_OVF_EN
         chk({"ovf_", name}, ovf, e.ovf);
`endif
         chk({"busy_done_", name}, busy, 0);
      end
      $display("op %s: diff=%02h borrow_out=%b", name, diff, borrow_out);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      exp_t e;
      int   t0;
      e.diff = v.e_diff; e.borrow = v.e_borrow; e.ovf = v.e_ovf;
      sb.push_back(e);
      t0 = ticks;
      begin_op(v.junk);
      feed_bits(v.a, v.b, W - 1, v.gaps);
      chk({"no_early_done_", name}, done, 0);
      feed_bits(v.a >> (W - 1), v.b >> (W - 1), 1, v.gaps);
      finish_op(name, t0, v.gaps ? 2 * W + 1 : W + 1);
   endtask

   function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit gaps, input bit junk,
                               input logic [W-1:0] ed, input bit eb, input bit eo);
      vec_t v;
      v.a = a; v.b = b; v.gaps = gaps; v.junk = junk;
      v.e_diff = ed; v.e_borrow = eb; v.e_ovf = eo;
      return v;
   endfunction

   initial begin
      exp_t         e;
      vec_t         v;
      logic [W-1:0] ra, rb, held;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      #12;
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef RESTADOR_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      tick();
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // Hand-derived expectations.
      vecs.push_back(mk(8'd100, 8'd37,  1'b0, 1'b0, 8'd63,  1'b0, 1'b0));
      vecs.push_back(mk(8'd5,   8'd9,   1'b0, 1'b1, 8'hFC,  1'b1, 1'b0));
      vecs.push_back(mk(8'h80,  8'h01,  1'b0, 1'b0, 8'h7F,  1'b0, 1'b1));
      vecs.push_back(mk(8'd200, 8'd200, 1'b1, 1'b0, 8'h00,  1'b0, 1'b0));
      vecs.push_back(mk(8'h00,  8'h01,  1'b0, 1'b1, 8'hFF,  1'b1, 1'b0));
      vecs.push_back(mk(8'h7F,  8'hFF,  1'b0, 1'b0, 8'h80,  1'b1, 1'b1));
      vecs.push_back(mk(8'h00,  8'h80,  1'b1, 1'b0, 8'h80,  1'b1, 1'b1));
      vecs.push_back(mk(8'hFF,  8'h00,  1'b0, 1'b0, 8'hFF,  1'b0, 1'b0));
      // Random operands checked against the reference model.
      for (int i = 0; i < 4; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         e  = model(ra, rb);
         vecs.push_back(mk(ra, rb, 1'(i % 2), 1'b0, e.diff, e.borrow, e.ovf));
      end

      foreach (vecs[i]) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // DONE ignores in_valid; result holds.
      held = diff;
      feed_bits(8'hAA, 8'h55, 3, 1'b0);
      chk("done_hold_diff", diff, held);
      chk("done_hold_done", done, 1);

      // done stays high in the start cycle, drops on the following edge.
      start    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("done_during_start", done, 1);
      tick();
      start = 1'b0;
      chk("done_after_restart", done, 0);
      chk("busy_after_restart", busy, 1);
      // Partial op, then abort with a bit presented in the restart cycle.
      feed_bits(8'hFF, 8'h00, 4, 1'b0);
      e = model(8'h0F, 8'h0E);
      sb.push_back(e);
      v = mk(8'h0F, 8'h0E, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
      begin_op(1'b1);
      feed_bits(v.a, v.b, W, 1'b0);
      finish_op("restart_0F_0E", 0, 0);
      chk("restart_diff_const", diff, 8'h01);

      // Asynchronous reset mid-operation.
      begin_op(1'b0);
      feed_bits(8'hF3, 8'h11, 3, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_diff", diff, 0);
      chk("arst_borrow", borrow_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
`ifdef RESTADOR_OVF_EN
      chk("arst_ovf", ovf, 0);
`endif
      tick();
      rst = 1'b0;
      tick();
      run_vec(mk(8'd7, 8'd3, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0), "after_rst_7_3");

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/restador_serial.md
# restador_serial

Bit-serial N-bit subtractor and the arithmetic inverse of the team's 1-bit adder datapath. It takes two operands one bit per cycle, LSB first, and computes A − B with a registered borrow chain. When the last bit is in, it presents the parallel difference and the final borrow. It sits between the serial input pins and the result/readback logic of the tile.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; begins (or restarts) an operation
- in_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
- a_bit  input  1  minuend bit, LSB first
- b_bit  input  1  subtrahend bit, LSB first
- busy  output  1  high while in RUN
- done  output  1  high while in DONE; result stable
- diff  output  WIDTH  A − B mod 2^WIDTH
- borrow_out  output  1  1 when A < B (unsigned)
- ovf  output  1  signed overflow; present only with RESTADOR_OVF_EN

## Operation
- States: IDLE, RUN, DONE.
- Reset (asynchronous, any state): go to IDLE; diff = 0, borrow_out = 0, busy = 0, done = 0, ovf = 0; internal borrow and bit counter = 0.
- IDLE, start = 1: go to RUN; counter = 0, borrow = 0, diff = 0. An in_valid arriving in the same cycle is ignored.
- RUN, in_valid = 1 (and start = 0):
  - Difference bit d = a ^ b ^ borrow.
  - Next borrow = (~a & b) | (~(a ^ b) & borrow).
  - diff shifts right by one and d enters at bit WIDTH-1, so after WIDTH bits diff[0] is the first bit received.
  - Counter increments.
- RUN, in_valid = 0: hold all state; gaps of any length are allowed.
- RUN, accepting the bit with counter = WIDTH-1: go to DONE; borrow_out = final borrow.
- RUN, start = 1: abort and restart. Same effect as start in IDLE; the bit accepted in that cycle, if any, is discarded.
- DONE: diff, borrow_out and ovf hold; in_valid is ignored.
- DONE, start = 1: go to RUN exactly as from IDLE. There is no return to IDLE except by reset.
- Arithmetic: unsigned modulo 2^WIDTH; borrow_out is the inverted carry of A + ~B + 1.

## Timing
- One operand bit is accepted per clk edge with in_valid = 1 in RUN.
- busy rises one cycle after start.
- done rises on the edge that accepts the WIDTH-th bit, so it is visible in the following cycle. Minimum latency is WIDTH+1 cycles from start to done.
- busy and done are never high together.
- done stays high until the cycle after the next start, or until reset.
- diff is intermediate (partial shift) while busy. It is valid only while done = 1.
- Outputs come straight from registers; there are no combinational paths from inputs to outputs.

## Configuration
- RESTADOR_OVF_EN defined:
  - The ovf port and its logic exist.
  - On the final bit: ovf = (a_msb ≠ b_msb) & (d_msb ≠ a_msb).
  - ovf is registered with borrow_out, cleared by start and by reset.
- RESTADOR_OVF_EN undefined:
  - No ovf port and no overflow logic.
  - All other behaviour is identical.

## Structure
- Shared package restador_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the default WIDTH constant
  - the counter-width function clog2(WIDTH)
- Sub-module resta_1bit: a combinational full subtractor (a, b, bin → d, bout), the counterpart of the existing 1-bit adder cell. It is instantiated once. The top level holds the FSM, counter, borrow flop and shift register.

## Test plan
- 100 − 37, WIDTH = 8, bits back-to-back → done after 9 cycles; diff = 8'd63, borrow_out = 0, ovf = 0.
- 5 − 9 → diff = 8'hFC, borrow_out = 1; with RESTADOR_OVF_EN, ovf = 0.
- 8'h80 − 8'h01 with RESTADOR_OVF_EN → diff = 8'h7F, borrow_out = 0, ovf = 1.
- 200 − 200 with in_valid low every other cycle → done after 8 accepted bits only; diff = 0, borrow_out = 0; busy stays high through the gaps.
- Start again after 4 bits, then feed 8'h0F − 8'h0E → diff = 8'h01; the first partial operation leaves no trace.
- Assert rst after 3 bits (asynchronously, mid-cycle) → all outputs 0 immediately. A following start plus 8'd7 − 8'd3 gives diff = 8'd4.
